memory_driver_param: RTL
========================

// Module: memory_driver_param
// PURPOSE
//  Parametrised serial-to-memory write driver. Deserialises a gated 1-bit stream into WIDTH-bit words and
//  issues one-cycle write strobes with incrementing address into a DEPTH-word memory; stops and flags when full.
//  Sits between a serial source and a single-port RAM write port; exposes FSM state for debug.
// PARAMETERS
//  WIDTH      8   bits per memory word (>=2)
//  DEPTH      16  number of memory words (>=2, need not be power of two); AW = $clog2(DEPTH) derived localparam
//  MSB_FIRST  1   1: first received bit lands in wdata[WIDTH-1]; 0: first bit lands in wdata[0]
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        asynchronous, active-low reset
//  start          in   1        begin capture (honoured only in IDLE)
//  clear          in   1        synchronous return to IDLE, clears counters/flags
//  data_valid     in   1        data_in qualifier
//  data_in        in   1        serial data bit
//  write          out  1        memory write strobe, one cycle per word
//  addr           out  AW       write address, valid while write=1
//  wdata          out  WIDTH    assembled word, valid while write=1
//  word_count     out  AW+1     words written since clear/reset, saturates at DEPTH
//  current_state  out  2        registered FSM state
//  next_state     out  2        combinational next state
//  stop           out  1        capture halted (FULL)
//  memory_full    out  1        sticky: DEPTH words written
//  overflow       out  1        sticky: data_valid seen while FULL
// BEHAVIOUR
//  - Reset (rst=0): state IDLE; all outputs, address, bit counter, shift reg 0; immediate, incl. mid-word.
//  - States: IDLE=2'b00, SHIFT=2'b01, WRITE=2'b10, FULL=2'b11.
//  - IDLE: data_valid ignored; start=1 -> SHIFT.
//  - SHIFT: each data_valid shifts data_in into shift reg (per MSB_FIRST), bit_cnt++; on WIDTH-th bit -> WRITE.
//  - WRITE: exactly one cycle; write=1, addr=current address, wdata=word. Latency: write asserted the cycle
//    after the edge sampling the last bit. data_valid during WRITE is accepted as bit 1 of next word (no loss,
//    back-to-back stream supported). Exit: addr==DEPTH-1 -> FULL (memory_full=1, stop=1), else addr++ -> SHIFT.
//  - FULL: no writes; addr holds DEPTH-1; data_valid sets overflow; start ignored; leave only via clear/reset.
//  - clear: priority over every other input; next edge -> IDLE, addr/bit_cnt/word_count/flags 0, partial word dropped.
//  - start outside IDLE ignored. write, addr, wdata, stop, memory_full, overflow are registered outputs.
//  - word_count increments in WRITE cycle, saturates at DEPTH (never wraps).
// CONFIGURATION
//  MEMDRV_WRAP_EN defined: circular buffer; after writing DEPTH-1, addr wraps to 0 and FSM returns to SHIFT;
//    memory_full set sticky on first wrap; stop and overflow stay 0; FULL unreachable.
//  MEMDRV_WRAP_EN undefined: halt in FULL as above.
// TESTING (WIDTH=4, DEPTH=4, MSB_FIRST=1 unless noted)
//  1. start, bits 1,0 then rst=0 -> all outputs 0, current_state 2'b00 without clock edge; release, no spurious write.
//  2. start, valid bits 1,0,1,1 -> single write pulse, addr=0, wdata=4'b1011, word_count=1, back to SHIFT.
//  3. gapless 8-bit stream 1011_0110 -> writes (0,4'b1011),(1,4'b0110); bit during WRITE cycle not lost.
//  4. 16 valid bits -> writes addr 0..3, then memory_full=1, stop=1, state 2'b11; 3 more bits -> overflow=1, no write.
//  5. clear in FULL -> IDLE next edge, addr 0, word_count 0, flags 0; MSB_FIRST=0 run: bits 1,0,1,1 -> wdata=4'b1101.
//  6. MEMDRV_WRAP_EN: 20 valid bits -> 5th word at addr 0, memory_full=1, stop=0, overflow=0, word_count=4.

Source files
------------

// File: rtl/memory_driver_param.sv
// Serial-to-memory write driver: deserialises gated bits into WIDTH-bit words and writes them to successive addresses.
// Optional build macro MEMDRV_WRAP_EN turns the address range into a circular buffer instead of halting when full.
module memory_driver_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic            data_valid,
    input  logic            data_in,
    output logic            write,
    output logic [AW-1:0]   addr,
    output logic [WIDTH-1:0] wdata,
    output logic [AW:0]     word_count,
    output logic [1:0]      current_state,
    output logic [1:0]      next_state,
    output logic            stop,
    output logic            memory_full,
    output logic            overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        WRITE = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_shifted, wdata_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [AW-1:0]    addr_q;
    logic [AW:0]      wc_q;
    logic             write_q, stop_q, full_q, ovf_q;
    logic             shift_in, word_done, last_addr;

    // Bits arriving during the WRITE cycle start the next word, so the stream may be gapless.
    assign shift_in  = data_valid && (state_q == SHIFT || state_q == WRITE);
    assign word_done = data_valid && (state_q == SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));
    assign last_addr = (addr_q == AW'(DEPTH - 1));

    always_comb begin
        sr_shifted = sr_q;
        if (MSB_FIRST)
            sr_shifted = {sr_q[WIDTH-2:0], data_in};
        else
            sr_shifted = {data_in, sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start) state_d = SHIFT;
                SHIFT: if (word_done) state_d = WRITE;
`ifdef MEMDRV_WRAP_EN
                WRITE: state_d = SHIFT;
`else
                WRITE: state_d = last_addr ? FULL : SHIFT;
`endif
                FULL:  state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wc_q      <= '0;
            write_q   <= 1'b0;
            stop_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clear) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wc_q      <= '0;
            write_q   <= 1'b0;
            stop_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            write_q <= word_done;
            if (shift_in) begin
                if (word_done) begin
                    wdata_q   <= sr_shifted;
                    sr_q      <= '0;
                    bit_cnt_q <= '0;
                    if (wc_q != (AW+1)'(DEPTH))
                        wc_q <= wc_q + 1'b1;
                end else begin
                    sr_q      <= sr_shifted;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
            if (state_q == WRITE) begin
                if (last_addr) begin
                    full_q <= 1'b1;
`ifdef MEMDRV_WRAP_EN
                    addr_q <= '0;
`else
                    stop_q <= 1'b1;
`endif
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            if (state_q == FULL && data_valid)
                ovf_q <= 1'b1;
        end
    end

    assign write         = write_q;
    assign addr          = addr_q;
    assign wdata         = wdata_q;
    assign word_count    = wc_q;
    assign current_state = state_q;
    assign next_state    = state_d;
    assign stop          = stop_q;
    assign memory_full   = full_q;
    assign overflow      = ovf_q;

endmodule
